// File: rtl/pulse_width_counter_mc.sv
// Multi-channel pulse-width counter: per-channel high/low phase
// measurement in prescaled ticks, results arbitrated onto one stream.
module pulse_width_counter_mc #(
    parameter int CH    = 2,
    parameter int W     = 23,
    parameter int SYNC  = 3,
    parameter int PRESC = 3,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk_12mhz,
    input  logic              reset,
    input  logic [CH-1:0]     cnt,
    input  logic [CH-1:0]     en,
    input  logic              mode,
    output logic [CH*W-1:0]   count_p,
    output logic [CH*W-1:0]   count_m,
    output logic [W:0]        out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH-1:0]     overrun,
    input  logic              clr_overrun
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int AW = $clog2(SYNC + 1);

    logic [PW-1:0]         presc;
    logic                  tick;
    logic [AW-1:0]         arm_cnt;
    logic                  armed;
    logic [CH-1:0]         pending;
    logic [CH-1:0]         unload;
    logic [CH*(W+1)-1:0]   res_flat;
    logic [CW-1:0]         rr_ptr;
    logic [CW-1:0]         grant_ch;
    logic                  grant_any;
    logic                  load;
    logic [W:0]            sel_res;

    assign tick  = (presc == PW'(PRESC - 1));
    assign armed = (arm_cnt == AW'(SYNC));
    assign load  = !out_valid || out_ready;

    // Free-running tick prescaler
    always_ff @(posedge clk_12mhz or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Hold off edge detection until the synchronisers hold real samples
    always_ff @(posedge clk_12mhz or negedge reset) begin
        if (!reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC-1:0] sq;
        logic [W-1:0]    p_cnt;
        logic [W-1:0]    m_cnt;
        logic [W-1:0]    cp;
        logic [W-1:0]    cm;
        logic [W:0]      res;
        logic            pend_q;
        logic            ovr_q;
        logic            rise;
        logic            fall;
        logic            inc;
        logic [W:0]      result;

        assign rise = armed && (sq[SYNC-1:SYNC-2] == 2'b01);
        assign fall = armed && (sq[SYNC-1:SYNC-2] == 2'b10);
        assign inc  = tick && en[i];

        assign result = mode ? {1'b0, p_cnt}
                             : ({1'b0, p_cnt} - {1'b0, cm});

        // Input synchroniser shift register
        always_ff @(posedge clk_12mhz or negedge reset) begin
            if (!reset) begin
                sq <= '0;
            end else begin
                sq <= {sq[SYNC-2:0], cnt[i]};
            end
        end

        // Phase counters with edge latching and saturation
        always_ff @(posedge clk_12mhz or negedge reset) begin
            if (!reset) begin
                p_cnt <= '0;
                m_cnt <= '0;
                cp    <= '0;
                cm    <= '0;
            end else if (rise) begin
                cm    <= m_cnt;
                m_cnt <= '0;
                p_cnt <= {{(W-1){1'b0}}, inc};
            end else if (fall) begin
                cp    <= p_cnt;
                p_cnt <= '0;
                m_cnt <= {{(W-1){1'b0}}, inc};
            end else if (inc) begin
                if (sq[SYNC-1]) begin
                    if (p_cnt != '1) p_cnt <= p_cnt + 1'b1;
                end else begin
                    if (m_cnt != '1) m_cnt <= m_cnt + 1'b1;
                end
            end
        end

        // Per-period result slot, pending flag and sticky overrun
        always_ff @(posedge clk_12mhz or negedge reset) begin
            if (!reset) begin
                res    <= '0;
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                if (fall) begin
                    res    <= result;
                    pend_q <= 1'b1;
                end else if (unload[i]) begin
                    pend_q <= 1'b0;
                end
                if (fall && pend_q && !unload[i]) begin
                    ovr_q <= 1'b1;
                end else if (clr_overrun) begin
                    ovr_q <= 1'b0;
                end
            end
        end

        assign pending[i]              = pend_q;
        assign overrun[i]              = ovr_q;
        assign count_p[i*W +: W]       = cp;
        assign count_m[i*W +: W]       = cm;
        assign res_flat[i*(W+1) +: W+1] = res;
    end

    // Round-robin search starting at the pointer
    always_comb begin
        logic [CW:0] sum;
        grant_any = 1'b0;
        grant_ch  = '0;
        sum       = '0;
        for (int k = 0; k < CH; k++) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(CH)) sum = sum - (CW+1)'(CH);
            if (!grant_any && pending[sum[CW-1:0]]) begin
                grant_any = 1'b1;
                grant_ch  = sum[CW-1:0];
            end
        end
    end

    // Unload strobe and result mux for the granted channel
    always_comb begin
        unload  = '0;
        sel_res = '0;
        for (int j = 0; j < CH; j++) begin
            if (grant_ch == CW'(j)) begin
                sel_res = res_flat[j*(W+1) +: W+1];
                unload[j] = load && grant_any;
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk_12mhz or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_data  <= sel_res;
                out_ch    <= grant_ch;
                out_valid <= 1'b1;
                rr_ptr    <= (grant_ch == CW'(CH - 1)) ? '0
                                                       : grant_ch + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_counter_mc.sv
// Directed testbench for pulse_width_counter_mc (CH=2, W=8).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_pulse_width_counter_mc;

    logic        clk_12mhz;
    logic        reset;
    logic [1:0]  cnt;
    logic [1:0]  en;
    logic        mode;
    logic [15:0] count_p;
    logic [15:0] count_m;
    logic [8:0]  out_data;
    logic [0:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  overrun;
    logic        clr_overrun;

    int checks = 0;
    int errors = 0;

    pulse_width_counter_mc #(
        .CH(2), .W(8), .SYNC(3), .PRESC(3)
    ) dut (
        .clk_12mhz  (clk_12mhz),
        .reset      (reset),
        .cnt        (cnt),
        .en         (en),
        .mode       (mode),
        .count_p    (count_p),
        .count_m    (count_m),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk_12mhz = 1'b0;
    always #42 clk_12mhz = ~clk_12mhz;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk_12mhz);
    endtask

    initial begin
        #(84 * 20000);
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        cnt         = 2'b00;
        en          = 2'b11;
        mode        = 1'b0;
        out_ready   = 1'b1;
        clr_overrun = 1'b0;
        hold(2);
        chk("rst_count_p", 32'(count_p), 32'h0);
        chk("rst_count_m", 32'(count_m), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_ch", 32'(out_ch), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b1;
        hold(5);

        // 30 high / 60 low, signed result
        for (int per = 0; per < 3; per++) begin
            cnt[0] = 1'b1;
            hold(30);
            cnt[0] = 1'b0;
            hold(3);
            if (per > 0) begin
                chk("t1_count_p", 32'(count_p[7:0]), 32'd10);
                chk("t1_count_m", 32'(count_m[7:0]), 32'd20);
                chk("t1_lat_idle", 32'(out_valid), 32'h0);
            end
            hold(1);
            chk("t1_valid", 32'(out_valid), 32'h1);
            if (per > 0) begin
                chk("t1_data", 32'(out_data), 32'h1F6);
                chk("t1_ch", 32'(out_ch), 32'h0);
            end
            hold(1);
            chk("t1_drop", 32'(out_valid), 32'h0);
            hold(55);
        end

        // Saturation: 900 cycles high
        cnt[0] = 1'b1;
        hold(900);
        cnt[0] = 1'b0;
        hold(3);
        chk("t2_sat_p", 32'(count_p[7:0]), 32'd255);
        chk("t2_count_m", 32'(count_m[7:0]), 32'd20);
        hold(1);
        chk("t2_data", 32'(out_data), 32'h0EB);
        hold(20);

        // Backpressure and overrun, raw mode
        mode      = 1'b1;
        out_ready = 1'b0;
        cnt[0] = 1'b1; hold(6); cnt[0] = 1'b0; hold(4);
        chk("t3_valid1", 32'(out_valid), 32'h1);
        chk("t3_data1", 32'(out_data), 32'd2);
        hold(5);
        cnt[0] = 1'b1; hold(9); cnt[0] = 1'b0; hold(4);
        chk("t3_ovr_none", 32'(overrun), 32'h0);
        chk("t3_data_hold2", 32'(out_data), 32'd2);
        hold(5);
        cnt[0] = 1'b1; hold(12); cnt[0] = 1'b0; hold(4);
        chk("t3_ovr_set", 32'(overrun), 32'h1);
        chk("t3_data_hold3", 32'(out_data), 32'd2);
        chk("t3_valid_hold", 32'(out_valid), 32'h1);
        hold(5);
        clr_overrun = 1'b1;
        hold(1);
        clr_overrun = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        hold(1);
        chk("t3_third_valid", 32'(out_valid), 32'h1);
        chk("t3_third_data", 32'(out_data), 32'd4);
        hold(1);
        chk("t3_empty", 32'(out_valid), 32'h0);

        // Round-robin with simultaneous falls
        reset = 1'b0;
        hold(2);
        reset = 1'b1;
        hold(5);
        cnt = 2'b01; hold(6); cnt = 2'b11; hold(9); cnt = 2'b00;
        hold(4);
        chk("t4a_ch", 32'(out_ch), 32'h0);
        chk("t4a_data", 32'(out_data), 32'd5);
        hold(1);
        chk("t4b_valid", 32'(out_valid), 32'h1);
        chk("t4b_ch", 32'(out_ch), 32'h1);
        chk("t4b_data", 32'(out_data), 32'd3);
        hold(1);
        chk("t4b_drop", 32'(out_valid), 32'h0);
        hold(10);
        cnt = 2'b10; hold(3); cnt = 2'b11; hold(9); cnt = 2'b00;
        hold(4);
        chk("t4c_ch", 32'(out_ch), 32'h0);
        chk("t4c_data", 32'(out_data), 32'd3);
        hold(1);
        chk("t4d_ch", 32'(out_ch), 32'h1);
        chk("t4d_data", 32'(out_data), 32'd4);
        hold(10);
        cnt = 2'b01; hold(6); cnt = 2'b00; hold(4);
        chk("t4e_ch", 32'(out_ch), 32'h0);
        chk("t4e_data", 32'(out_data), 32'd2);
        hold(10);
        cnt = 2'b11; hold(9); cnt = 2'b00; hold(4);
        chk("t4f_ch", 32'(out_ch), 32'h1);
        hold(1);
        chk("t4g_ch", 32'(out_ch), 32'h0);
        chk("t4g_data", 32'(out_data), 32'd3);
        hold(10);

        // Enable gating on ch1
        cnt[1] = 1'b1; hold(5);
        en[1] = 1'b0; hold(15);
        en[1] = 1'b1; hold(10);
        cnt[1] = 1'b0; hold(3);
        chk("t5_count_p1", 32'(count_p[15:8]), 32'd5);
        hold(1);
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_ch", 32'(out_ch), 32'h1);
        chk("t5_data", 32'(out_data), 32'd5);
        hold(10);

        // Reset mid high phase with input held high
        out_ready = 1'b0;
        cnt[0] = 1'b1; hold(6); cnt[0] = 1'b0; hold(10);
        chk("t6_pre_valid", 32'(out_valid), 32'h1);
        cnt[0] = 1'b1;
        hold(10);
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_count_p", 32'(count_p), 32'h0);
        chk("t6_count_m", 32'(count_m), 32'h0);
        chk("t6_data", 32'(out_data), 32'h0);
        chk("t6_overrun", 32'(overrun), 32'h0);
        hold(2);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 28; c++) begin
            hold(1);
            chk("t6_no_emit", 32'(out_valid), 32'h0);
        end
        cnt[0] = 1'b0;
        hold(3);
        chk("t6_count_p0", 32'(count_p[7:0]), 32'd9);
        chk("t6_count_m0", 32'(count_m[7:0]), 32'd0);
        hold(1);
        chk("t6_out_valid", 32'(out_valid), 32'h1);
        chk("t6_out_data", 32'(out_data), 32'd9);
        chk("t6_out_ch", 32'(out_ch), 32'h0);
        hold(5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
